// File: rtl/ddr2_blk_rdwr_gearbox_fifo_pkg.sv
// Shared constants and types for the ddr2_blk_rdwr width-converting FIFOs.
package ddr2_blk_rdwr_gearbox_fifo_pkg;

    // Bits per byte lane.
    localparam int BYTE_W    = 8;
    // Widest input or output word any converter in this family supports, in bytes.
    localparam int MAX_BYTES = 16;

    // Byte-count width that can hold 0..in_bytes+out_bytes.
    function automatic int cnt_width(input int in_bytes, input int out_bytes);
        return $clog2(in_bytes + out_bytes + 1);
    endfunction

    // Flush controller states.
    typedef enum logic [0:0] {
        FLUSH_IDLE = 1'b0,
        FLUSH_PEND = 1'b1
    } flush_state_e;

endpackage

// File: rtl/ddr2_blk_rdwr_gearbox_fifo_small_fifo.sv
// Small fall-through FIFO: the head entry is visible on dout while not empty.
module ddr2_blk_rdwr_gearbox_fifo_small_fifo #(
    parameter int WIDTH          = 64,
    parameter int MAX_DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem_r [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
    logic [MAX_DEPTH_BITS:0]   depth_r;
    logic                      do_wr_s;
    logic                      do_rd_s;

    // Qualify the strobes against the current occupancy.
    always_comb begin
        do_wr_s = wr_en && (depth_r != (MAX_DEPTH_BITS + 1)'(DEPTH));
        do_rd_s = rd_en && (depth_r != {(MAX_DEPTH_BITS + 1){1'b0}});
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
            rd_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
            depth_r  <= {(MAX_DEPTH_BITS + 1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + {{(MAX_DEPTH_BITS - 1){1'b0}}, 1'b1};
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + {{(MAX_DEPTH_BITS - 1){1'b0}}, 1'b1};
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   depth_r <= depth_r + {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
                2'b01:   depth_r <= depth_r - {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
                default: depth_r <= depth_r;
            endcase
        end
    end

    assign dout        = mem_r[rd_ptr_r];
    assign empty       = (depth_r == {(MAX_DEPTH_BITS + 1){1'b0}});
    assign nearly_full = (depth_r >= (MAX_DEPTH_BITS + 1)'(DEPTH - 1));

endmodule

// File: rtl/ddr2_blk_rdwr_gearbox_fifo.sv
// Byte-granular width converter: IN_BYTES words in, OUT_BYTES words out, first byte in is
// the MS byte out. A flush drains every accepted byte, zero-padding the final short word.
module ddr2_blk_rdwr_gearbox_fifo
    import ddr2_blk_rdwr_gearbox_fifo_pkg::*;
#(
    parameter  int IN_BYTES        = 8,
    parameter  int OUT_BYTES       = 9,
    parameter  int FIFO_DEPTH_BITS = 4,
    localparam int CNT_W           = cnt_width(IN_BYTES, OUT_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BYTE_W*IN_BYTES-1:0]  wr_data,
    input  logic                      wr_en,
    input  logic                      flush,
    output logic                      full,
    output logic                      wr_err,
    input  logic                      rd_en,
    output logic [BYTE_W*OUT_BYTES-1:0] rd_data,
    output logic [CNT_W-1:0]          rd_bytes,
    output logic [BYTE_W*OUT_BYTES-1:0] rd_data_d1,
    output logic                      empty
);

    localparam int ACC_BYTES = IN_BYTES + OUT_BYTES;
    localparam int ACC_W     = BYTE_W * ACC_BYTES;
    localparam int IN_W      = BYTE_W * IN_BYTES;
    localparam int OUT_W     = BYTE_W * OUT_BYTES;

    logic [IN_W-1:0]  fifo_dout_s;
    logic             fifo_empty_s;
    logic             fifo_nfull_s;
    logic             fifo_wr_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_shift_s;
    logic [ACC_W-1:0] acc_load_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] rd_bytes_s;
    logic [CNT_W-1:0] cons_s;
    logic [CNT_W-1:0] rem_s;
    logic [OUT_W-1:0] rd_data_s;
    logic [OUT_W-1:0] rd_data_d1_r;
    logic             wr_err_r;
    logic             empty_s;
    logic             full_s;
    logic             rd_fire_s;
    logic             load_s;
    logic             flush_pend_s;
    flush_state_e     fstate_r;
    flush_state_e     fstate_nxt_s;

    // Input word FIFO; the accumulator pops it whenever a whole word fits.
    ddr2_blk_rdwr_gearbox_fifo_small_fifo #(
        .WIDTH          (IN_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .rst         (rst),
        .din         (wr_data),
        .wr_en       (fifo_wr_s),
        .rd_en       (load_s),
        .dout        (fifo_dout_s),
        .empty       (fifo_empty_s),
        .nearly_full (fifo_nfull_s)
    );

    // Output view: top OUT_BYTES of the accumulator with invalid bytes forced to zero.
    always_comb begin
        rd_data_s = {OUT_W{1'b0}};
        for (int k = 0; k < OUT_BYTES; k++) begin
            rd_data_s[OUT_W-1-BYTE_W*k -: BYTE_W] = (cnt_r > CNT_W'(k)) ?
                acc_r[ACC_W-1-BYTE_W*k -: BYTE_W] : {BYTE_W{1'b0}};
        end
        rd_bytes_s = (cnt_r >= CNT_W'(OUT_BYTES)) ? CNT_W'(OUT_BYTES) : cnt_r;
        empty_s    = !((cnt_r >= CNT_W'(OUT_BYTES)) ||
                       (flush_pend_s && fifo_empty_s && (cnt_r != {CNT_W{1'b0}})));
    end

    // Consume the read bytes and append the FIFO head below what remains, same cycle.
    always_comb begin
        rd_fire_s   = rd_en && !empty_s;
        cons_s      = rd_fire_s ? rd_bytes_s : {CNT_W{1'b0}};
        rem_s       = cnt_r - cons_s;
        load_s      = !fifo_empty_s && (rem_s <= CNT_W'(OUT_BYTES));
        acc_shift_s = acc_r;
        for (int s = 1; s <= OUT_BYTES; s++) begin
            acc_shift_s = (cons_s == CNT_W'(s)) ? (acc_r << (BYTE_W * s)) : acc_shift_s;
        end
        acc_load_s = {ACC_W{1'b0}};
        for (int r = 0; r <= OUT_BYTES; r++) begin
            acc_load_s = (load_s && (rem_s == CNT_W'(r))) ?
                ({fifo_dout_s, {OUT_W{1'b0}}} >> (BYTE_W * r)) : acc_load_s;
        end
        cnt_nxt_s = load_s ? (rem_s + CNT_W'(IN_BYTES)) : rem_s;
    end

    // Flush state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_r <= FLUSH_IDLE;
        end else begin
            fstate_r <= fstate_nxt_s;
        end
    end

    // Flush next state: leave pending once nothing remains buffered after this cycle.
    always_comb begin
        fstate_nxt_s = fstate_r;
        case (fstate_r)
            FLUSH_IDLE: fstate_nxt_s = flush ? FLUSH_PEND : FLUSH_IDLE;
            FLUSH_PEND: fstate_nxt_s = (fifo_empty_s && (cnt_nxt_s == {CNT_W{1'b0}})) ?
                                       FLUSH_IDLE : FLUSH_PEND;
            default:    fstate_nxt_s = FLUSH_IDLE;
        endcase
    end

    // Flush outputs: a pending flush blocks further writes.
    always_comb begin
        case (fstate_r)
            FLUSH_PEND: flush_pend_s = 1'b1;
            FLUSH_IDLE: flush_pend_s = 1'b0;
            default:    flush_pend_s = 1'b0;
        endcase
        full_s    = fifo_nfull_s || flush_pend_s;
        fifo_wr_s = wr_en && !full_s;
    end

    // Accumulator, byte count, dropped-write flag and delayed read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            wr_err_r     <= 1'b0;
            rd_data_d1_r <= {OUT_W{1'b0}};
        end else begin
            acc_r    <= acc_shift_s | acc_load_s;
            cnt_r    <= cnt_nxt_s;
            wr_err_r <= wr_en && full_s;
            if (rd_fire_s) begin
                rd_data_d1_r <= rd_data_s;
            end
        end
    end

    assign full       = full_s;
    assign wr_err     = wr_err_r;
    assign rd_data    = rd_data_s;
    assign rd_bytes   = rd_bytes_s;
    assign rd_data_d1 = rd_data_d1_r;
    assign empty      = empty_s;

endmodule

// File: tb/tb_ddr2_blk_rdwr_gearbox_fifo.sv
`timescale 1ns/1ps
module tb_ddr2_blk_rdwr_gearbox_fifo;

    localparam int IN    = 8;
    localparam int OUT   = 9;
    localparam int DB    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int IW    = 8 * IN;
    localparam int OW    = 8 * OUT;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [IW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          flush = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, wr_err, empty;
    logic [OW-1:0] rd_data, rd_data_d1;
    logic [CW-1:0] rd_bytes;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ddr2_blk_rdwr_gearbox_fifo #(
        .IN_BYTES(IN), .OUT_BYTES(OUT), .FIFO_DEPTH_BITS(DB)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
        .full(full), .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data),
        .rd_bytes(rd_bytes), .rd_data_d1(rd_data_d1), .empty(empty)
    );

    // Reference model: a queue of pending input words and a queue of bytes held for output.
    logic [IW-1:0] m_fifo[$];
    logic [7:0]    m_acc[$];
    bit            m_fp = 1'b0;
    bit            m_werr = 1'b0;
    logic [OW-1:0] m_d1 = '0;

    function automatic int m_rdbytes();
        return (m_acc.size() < OUT) ? m_acc.size() : OUT;
    endfunction
    function automatic bit m_empty();
        return !(m_acc.size() >= OUT || (m_fp && m_fifo.size() == 0 && m_acc.size() != 0));
    endfunction
    function automatic bit m_full();
        return (m_fifo.size() >= DEPTH - 1) || m_fp;
    endfunction
    function automatic logic [OW-1:0] m_rddata();
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < m_rdbytes(); k++) r[OW-1-8*k -: 8] = m_acc[k];
        return r;
    endfunction

    // Advance the reference model once per clock using the same sampled inputs as the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_acc.delete();
            m_fp   <= 1'b0;
            m_werr <= 1'b0;
            m_d1   <= '0;
        end else begin
            automatic int            n  = m_rdbytes();
            automatic bit            e  = m_empty();
            automatic bit            f  = m_full();
            automatic bit            fe = (m_fifo.size() == 0);
            automatic logic [OW-1:0] rd = m_rddata();
            automatic logic [IW-1:0] w;
            m_werr <= wr_en && f;
            if (rd_en && !e) begin
                m_d1 <= rd;
                repeat (n) void'(m_acc.pop_front());
            end
            if (!fe && (m_acc.size() + IN <= IN + OUT)) begin
                w = m_fifo.pop_front();
                for (int k = 0; k < IN; k++) m_acc.push_back(w[IW-1-8*k -: 8]);
            end
            if (wr_en && !f) m_fifo.push_back(wr_data);
            if (m_fp) begin
                if (fe && m_acc.size() == 0) m_fp <= 1'b0;
            end else if (flush) begin
                m_fp <= 1'b1;
            end
        end
    end

    function automatic logic [IW-1:0] seq_word(input int base);
        logic [IW-1:0] w;
        for (int k = 0; k < IN; k++) w[IW-1-8*k -: 8] = 8'(base + k);
        return w;
    endfunction

    function automatic logic [OW-1:0] seq_out(input int base, input int nb);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < nb; k++) r[OW-1-8*k -: 8] = 8'(base + k);
        return r;
    endfunction

    task automatic step(input logic w, input logic [IW-1:0] d, input logic f, input logic r);
        wr_en = w; wr_data = d; flush = f; rd_en = r;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        vectors++; if (rd_bytes !== '0) begin miscompares++; $display("FAIL reset_rd_bytes: got %0d want 0", rd_bytes); end
        vectors++; if (rd_data_d1 !== '0) begin miscompares++; $display("FAIL reset_rd_data_d1: got %h want 0", rd_data_d1); end
        vectors++; if (wr_err !== 1'b0) begin miscompares++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_convert_64_72();
        logic [OW-1:0] exp_d;
        for (int j = 0; j < 9; j++) step(1'b1, seq_word(8 * j), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_d = seq_out(9 * i, 9);
            vectors++; if (rd_data !== exp_d) begin miscompares++; $display("FAIL conv_rd_data[%0d]: got %h want %h", i, rd_data, exp_d); end
            vectors++; if (rd_bytes !== CW'(9)) begin miscompares++; $display("FAIL conv_rd_bytes[%0d]: got %0d want 9", i, rd_bytes); end
            vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL conv_empty[%0d]: got %b want 0", i, empty); end
            step(1'b0, '0, 1'b0, 1'b1);
            vectors++; if (rd_data_d1 !== exp_d) begin miscompares++; $display("FAIL conv_d1[%0d]: got %h want %h", i, rd_data_d1, exp_d); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL conv_final_empty: got %b want 1", empty); end
    endtask

    task automatic test_flush_tail();
        logic [OW-1:0] exp_d;
        int            sizes[3] = '{9, 9, 6};
        int            base;
        step(1'b1, seq_word(0), 1'b0, 1'b0);
        step(1'b1, seq_word(8), 1'b0, 1'b0);
        step(1'b1, seq_word(16), 1'b1, 1'b0);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL flush_full_pending: got %b want 1", full); end
        step(1'b1, seq_word(100), 1'b0, 1'b0);
        vectors++; if (wr_err !== 1'b1) begin miscompares++; $display("FAIL flush_wr_err: got %b want 1", wr_err); end
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        base = 0;
        for (int i = 0; i < 3; i++) begin
            exp_d = seq_out(base, sizes[i]);
            vectors++; if (rd_bytes !== CW'(sizes[i])) begin miscompares++; $display("FAIL tail_rd_bytes[%0d]: got %0d want %0d", i, rd_bytes, sizes[i]); end
            vectors++; if (rd_data !== exp_d) begin miscompares++; $display("FAIL tail_rd_data[%0d]: got %h want %h", i, rd_data, exp_d); end
            vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL tail_empty[%0d]: got %b want 0", i, empty); end
            step(1'b0, '0, 1'b0, 1'b1);
            base += sizes[i];
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL tail_final_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL tail_final_full: got %b want 0", full); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int got = 0;
        for (int c = 0; c < 24; c++) begin
            if (!m_full()) accepted++;
            step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
            vectors++; if (full !== m_full()) begin miscompares++; $display("FAIL bp_full[%0d]: got %b want %b", c, full, m_full()); end
            vectors++; if (wr_err !== m_werr) begin miscompares++; $display("FAIL bp_wr_err[%0d]: got %b want %b", c, wr_err, m_werr); end
        end
        vectors++; if (accepted != DEPTH - 1 + 2) begin miscompares++; $display("FAIL bp_accepted: got %0d want %0d", accepted, DEPTH + 1); end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            vectors++; if (empty !== m_empty()) begin miscompares++; $display("FAIL bp_empty[%0d]: got %b want %b", c, empty, m_empty()); end
            vectors++; if (rd_data !== m_rddata()) begin miscompares++; $display("FAIL bp_rd_data[%0d]: got %h want %h", c, rd_data, m_rddata()); end
            if (!empty) got += int'(rd_bytes);
            step(1'b0, '0, 1'b0, 1'b1);
        end
        vectors++; if (got != 8 * accepted) begin miscompares++; $display("FAIL bp_bytes_out: got %0d want %0d", got, 8 * accepted); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got empty=%b full=%b want 1/0", empty, full); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            automatic bit last = (c >= 560);
            step(($urandom % 4) != 0 && !last, {$urandom, $urandom},
                 last ? (c == 560) : (($urandom % 40) == 0), ($urandom % 3) != 0 || last);
            vectors++; if (rd_data !== m_rddata()) begin miscompares++; $display("FAIL rnd_rd_data[%0d]: got %h want %h", c, rd_data, m_rddata()); end
            vectors++; if (rd_bytes !== CW'(m_rdbytes())) begin miscompares++; $display("FAIL rnd_rd_bytes[%0d]: got %0d want %0d", c, rd_bytes, m_rdbytes()); end
            vectors++; if (empty !== m_empty()) begin miscompares++; $display("FAIL rnd_empty[%0d]: got %b want %b", c, empty, m_empty()); end
            vectors++; if (full !== m_full()) begin miscompares++; $display("FAIL rnd_full[%0d]: got %b want %b", c, full, m_full()); end
            vectors++; if (wr_err !== m_werr) begin miscompares++; $display("FAIL rnd_wr_err[%0d]: got %b want %b", c, wr_err, m_werr); end
            vectors++; if (rd_data_d1 !== m_d1) begin miscompares++; $display("FAIL rnd_d1[%0d]: got %h want %h", c, rd_data_d1, m_d1); end
        end
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL rnd_drained: got empty=%b full=%b want 1/0", empty, full); end
    endtask

    task automatic test_reset_midstream();
        for (int j = 0; j < 4; j++) step(1'b1, seq_word(8 * j), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (rd_bytes !== CW'(5)) begin miscompares++; $display("FAIL mid_rd_bytes: got %0d want 5", rd_bytes); end
        vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL mid_pending: got full=%b empty=%b want 1/0", full, empty); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL mid_rst_flags: got empty=%b full=%b want 1/0", empty, full); end
        vectors++; if (rd_data !== '0 || rd_bytes !== '0) begin miscompares++; $display("FAIL mid_rst_data: got %h/%0d want 0/0", rd_data, rd_bytes); end
        vectors++; if (rd_data_d1 !== '0 || wr_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_regs: got %h/%b want 0/0", rd_data_d1, wr_err); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, seq_word(0), 1'b0, 1'b0);
        step(1'b1, seq_word(8), 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (rd_data !== seq_out(0, 9) || rd_bytes !== CW'(9)) begin miscompares++; $display("FAIL mid_fresh: got %h/%0d want %h/9", rd_data, rd_bytes, seq_out(0, 9)); end
    endtask

    initial begin
        test_reset();
        test_convert_64_72();
        test_flush_tail();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
